// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared fetch-stage types and constants for the RV32I pipeline
package pipeline_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_KILL} fetch_state_e;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } ifid_t;
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline entry with flush/load/hold, also used as the skid slot
module ifid_reg
  import pipeline_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [AW-1:0] RST_PC = '0,
  parameter logic [DW-1:0] NOP = pipeline_pkg::NOP_INSN
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          load_i,
  input  logic [AW-1:0] flush_pc_i,
  input  logic [DW-1:0] instr_i,
  input  logic [AW-1:0] pc_i,
  output logic [DW-1:0] instr_o,
  output logic [AW-1:0] pc_o,
  output logic          valid_o
);
  logic [DW-1:0] instr_q;
  logic [AW-1:0] pc_q;
  logic          valid_q;
  // flush wins over load; otherwise the entry holds
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      instr_q <= NOP;
      pc_q    <= RST_PC;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP;
      pc_q    <= flush_pc_i;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner and Wishbone classic instruction fetcher feeding IF/ID
module if_fetch_stage
  import pipeline_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR = 32'h8000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSN = pipeline_pkg::NOP_INSN
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall_i,
  input  logic                    redirect_i,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc_i,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  input  logic                    wb_ack_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   ifid_instr_o,
  output logic [ADDR_WIDTH-1:0]   ifid_pc_o,
  output logic                    ifid_valid_o
);
  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] pc_q, adr_q, pc_inc, tgt, skid_pc;
  logic [DATA_WIDTH-1:0] skid_instr;
  logic                  skid_valid, fetch_ack, skid_drain, ifid_load, skid_load;
  assign pc_inc     = pc_q + ADDR_WIDTH'(4);
  assign tgt        = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign fetch_ack  = state_q == S_FETCH && wb_ack_i;
  assign skid_drain = state_q == S_HOLD && !stall_i;
  assign ifid_load  = !redirect_i && ((fetch_ack && !stall_i) || (skid_drain && skid_valid));
  assign skid_load  = !redirect_i && fetch_ack && stall_i;
  // redirect overrides everything; an unacked request is finished in KILL and its data dropped
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC_ADDR;
      adr_q   <= PC_ADDR;
    end else if (redirect_i) begin
      pc_q <= tgt;
      if ((state_q == S_FETCH || state_q == S_KILL) && !wb_ack_i) state_q <= S_KILL;
      else begin
        state_q <= S_FETCH;
        adr_q   <= tgt;
      end
    end else
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          adr_q   <= pc_q;
        end
        S_FETCH: if (wb_ack_i) begin
          pc_q  <= pc_inc;
          adr_q <= pc_inc;
          if (stall_i) state_q <= S_HOLD;
        end
        S_HOLD: if (!stall_i) begin
          state_q <= S_FETCH;
          adr_q   <= pc_q;
        end
        default: if (wb_ack_i) begin
          state_q <= S_FETCH;
          adr_q   <= pc_q;
        end
      endcase
  ifid_reg #(
    .AW(ADDR_WIDTH), .DW(DATA_WIDTH), .RST_PC(PC_ADDR), .NOP(NOP_INSN)
  ) u_ifid (
    .clk(clk), .reset(reset), .flush_i(redirect_i), .load_i(ifid_load),
    .flush_pc_i(redirect_pc_i),
    .instr_i(skid_drain ? skid_instr : wb_dat_i),
    .pc_i(skid_drain ? skid_pc : pc_q),
    .instr_o(ifid_instr_o), .pc_o(ifid_pc_o), .valid_o(ifid_valid_o)
  );
  ifid_reg #(
    .AW(ADDR_WIDTH), .DW(DATA_WIDTH), .RST_PC(PC_ADDR), .NOP(NOP_INSN)
  ) u_skid (
    .clk(clk), .reset(reset), .flush_i(redirect_i || skid_drain), .load_i(skid_load),
    .flush_pc_i(pc_q), .instr_i(wb_dat_i), .pc_i(pc_q),
    .instr_o(skid_instr), .pc_o(skid_pc), .valid_o(skid_valid)
  );
  assign wb_cyc_o = state_q == S_FETCH || state_q == S_KILL;
  assign wb_stb_o = wb_cyc_o;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = '1;
  assign wb_adr_o = adr_q;
endmodule
